// File: rtl/bcd_serial_adder.sv
// ============================================================================
// bcd_serial_adder : digit-serial packed-BCD adder, LSD first, one digit/clk
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d, err_acc_q, err_acc_d, cout_q, cout_d, err_q, err_d;

  logic             accept;
  logic             last_digit;
  logic [3:0]       digit_a, digit_b, d_digit;
  logic [4:0]       t;
  logic             carry;
  logic             digit_err;
  logic [W-1:0]     acc_shift;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      err_acc_q <= 1'b0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      err_acc_q <= err_acc_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_ADD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decimal digit adder; out-of-range digits still follow the same correction rule
  always_comb begin
    digit_a   = a_q[3:0];
    digit_b   = b_q[3:0];
    t         = {1'b0, digit_a} + {1'b0, digit_b} + {4'd0, c_q};
    carry     = (t > 5'd9);
    d_digit   = carry ? (t[3:0] + 4'd6) : t[3:0];
    digit_err = (digit_a > 4'd9) || (digit_b > 4'd9);
    acc_shift = (acc_q >> 4) | (W'(d_digit) << (W - 4));
  end

  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_digit = (cnt_q == LAST_CNT);

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    if (accept) begin
      a_d       = a;
      b_d       = b;
      c_d       = cin;
      cnt_d     = '0;
      err_acc_d = 1'b0;
    end else if (state_q == S_ADD) begin
      a_d       = a_q >> 4;
      b_d       = b_q >> 4;
      c_d       = carry;
      acc_d     = acc_shift;
      cnt_d     = cnt_q + CNT_W'(1);
      err_acc_d = err_acc_q | digit_err;
      // Results are published only on the edge that enters DONE
      if (last_digit) begin
        sum_d  = acc_shift;
        cout_d = carry;
        err_d  = err_acc_q | digit_err;
      end
    end
  end

  // Outputs decode from registered state only
  always_comb begin
    busy = (state_q == S_ADD);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
    err  = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
// tb_bcd_serial_adder : directed self-checking bench for bcd_serial_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int compared   = 0;
  int mismatched = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n busy cycles in which the previous result must stay put
  task automatic expect_busy(input string tag, input int n, input logic [15:0] hold_sum);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(sum), 32'(hold_sum));
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input logic [15:0] es, input logic ec, input logic ee);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy0"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_err"}, 32'(err), 32'(ee));
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] prev,
                        input logic [15:0] es, input logic ec, input logic ee);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;  // later changes must not matter
    expect_busy(tag, DIGITS, prev);
    expect_done(tag, es, ec, ee);
    tick();
    check({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check("reset_outs", 32'({busy, done, cout, err}), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    tick();

    run_op("basic",   16'h1234, 16'h5678, 1'b0, 16'h0000, 16'h6912, 1'b0, 1'b0);
    run_op("wrap",    16'h9999, 16'h0001, 1'b0, 16'h6912, 16'h0000, 1'b1, 1'b0);
    run_op("cin",     16'h0999, 16'h0000, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0);
    run_op("baddig",  16'h00A0, 16'h0001, 1'b0, 16'h1000, 16'h0101, 1'b0, 1'b1);
    run_op("errclr",  16'h0001, 16'h0002, 1'b0, 16'h0101, 16'h0003, 1'b0, 1'b0);

    // start held through ADD: ignored until DONE, which then captures new operands
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h4444; b = 16'h1111;
    expect_busy("held1", DIGITS, 16'h0003);
    expect_done("held1", 16'h3333, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    a = 16'h0000; b = 16'h0000;
    expect_busy("held2", DIGITS, 16'h3333);
    expect_done("held2", 16'h5555, 1'b0, 1'b0);
    tick();

    // reset two edges into an operation aborts it
    a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    check("abort_outs", 32'({busy, done, cout, err}), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort_nodone", 32'({busy, done}), 32'd0);
      tick();
    end
    run_op("post_rst", 16'h0005, 16'h0005, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b0);

    // continuous start: a done pulse every DIGITS+1 cycles
    a = 16'h0100; b = 16'h0200; cin = 1'b0; start = 1'b1;
    tick();
    expect_busy("b2b1", DIGITS, 16'h0010);
    expect_done("b2b1", 16'h0300, 1'b0, 1'b0);
    a = 16'h0300; b = 16'h0400;
    tick();
    expect_busy("b2b2", DIGITS, 16'h0300);
    expect_done("b2b2", 16'h0700, 1'b0, 1'b0);
    a = 16'h9000; b = 16'h1000;
    tick();
    start = 1'b0;
    expect_busy("b2b3", DIGITS, 16'h0700);
    expect_done("b2b3", 16'h0000, 1'b1, 1'b0);
    tick();
    check("final_idle", 32'({busy, done}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
